// File: rtl/cpu_ad48_core.sv
// 48-bit single-issue core: one instruction per clock, M/S/U privilege, illegal traps, level IRQs.
// Instruction memory and data register file are separate instances (IMEM, RF_D).

module cpu_ad48_imem #(
  parameter int WORDS = 256,
  parameter int AW    = 8
) (
  input  logic [AW-1:0] addr,
  output logic [47:0]   data
);
  logic [47:0] mem [WORDS];
  assign data = mem[addr];
endmodule

module cpu_ad48_rf (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [2:0]  wa,
  input  logic [47:0] wd,
  input  logic [2:0]  ra0,
  input  logic [2:0]  ra1,
  output logic [47:0] rd0,
  output logic [47:0] rd1
);
  logic [47:0] regs [0:7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign rd0 = regs[ra0];
  assign rd1 = regs[ra1];
endmodule

module cpu_ad48_core #(
  parameter int IM_WORDS    = 256,
  parameter int DM_WORDS    = 32,
  parameter int IRQ_LINES   = 4,
  parameter int TRAP_VECTOR = 64
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [IRQ_LINES-1:0] irq,
  output logic                 halt
);
  localparam int IAW = $clog2(IM_WORDS);
  localparam int DAW = $clog2(DM_WORDS);
  localparam logic [5:0]  OP_ALUI = 6'h01, OP_LD = 6'h02, OP_ST = 6'h03;
  localparam logic [5:0]  OP_CSR = 6'h20, OP_SYS = 6'h3F;
  localparam logic [11:0] A_STATUS = 12'h000, A_CAUSE = 12'h001, A_EPC = 12'h002;
  localparam logic [11:0] A_LR = 12'h003, A_SCRATCH = 12'h004, A_CYCLE = 12'h005;
  localparam logic [47:0] STATUS_MASK = 48'h3FF;

  logic [47:0] pc, instr;
  logic [47:0] csr_status, csr_cause, csr_epc, csr_lr, csr_scratch, csr_cycle;
  logic [1:0]  priv_mode;
  logic        handler_active;
  logic [47:0] dmem [DM_WORDS];

  logic [47:0] pc_n, status_n, cause_n, epc_n, lr_n, scratch_n;
  logic [1:0]  mode_n;
  logic        ha_n, halt_n, rf_we, dm_we, ill, csr_known, alu_ok, ie_cur, irq_take;
  logic [47:0] rf_wd, rv0, rv1, imm, alu_res, csr_old, csr_wdata, irq_cause;
  logic [DAW-1:0] daddr;

  wire [5:0]  op    = instr[47:42];
  wire [7:0]  subop = instr[34:27];
  wire [3:0]  cfunc = instr[41:38];
  wire [11:0] caddr = instr[11:0];
  wire        is_csr = (op == OP_CSR);

  assign imm   = {{21{instr[26]}}, instr[26:0]};
  assign daddr = rv0[DAW-1:0] + imm[DAW-1:0];

  cpu_ad48_imem #(.WORDS(IM_WORDS), .AW(IAW)) IMEM (.addr(pc[IAW-1:0]), .data(instr));

  cpu_ad48_rf RF_D (
    .clk(clk), .rst(resetn), .we(rf_we),
    .wa(is_csr ? instr[36:34] : instr[40:38]), .wd(rf_wd),
    .ra0(is_csr ? instr[33:31] : instr[37:35]), .ra1(instr[40:38]),
    .rd0(rv0), .rd1(rv1)
  );

  always_comb begin
    irq_cause = '0;
    for (int i = IRQ_LINES - 1; i >= 0; i--)
      if (irq[i]) irq_cause = 48'(8 + i);
    case (priv_mode)
      2'd0:    ie_cur = csr_status[4];
      2'd1:    ie_cur = csr_status[5];
      2'd3:    ie_cur = csr_status[6];
      default: ie_cur = 1'b0;
    endcase
    irq_take = (|irq) && ie_cur && !handler_active && !halt;
  end

  always_comb begin
    alu_ok  = 1'b1;
    alu_res = '0;
    case (subop)
      8'd0:    alu_res = rv0 + imm;
      8'd1:    alu_res = rv0 - imm;
      8'd2:    alu_res = rv0 & imm;
      8'd3:    alu_res = rv0 | imm;
      8'd4:    alu_res = rv0 ^ imm;
      default: alu_ok = 1'b0;
    endcase
    csr_known = 1'b1;
    csr_old   = '0;
    case (caddr)
      A_STATUS:  csr_old = csr_status;
      A_CAUSE:   csr_old = csr_cause;
      A_EPC:     csr_old = csr_epc;
      A_LR:      csr_old = csr_lr;
      A_SCRATCH: csr_old = csr_scratch;
      A_CYCLE:   csr_old = csr_cycle;
      default:   csr_known = 1'b0;
    endcase
    case (cfunc)
      4'd2:    csr_wdata = csr_old | rv0;
      4'd3:    csr_wdata = csr_old & ~rv0;
      default: csr_wdata = rv0;
    endcase
  end

  always_comb begin
    pc_n = pc + 48'd1;
    status_n = csr_status; cause_n = csr_cause; epc_n = csr_epc;
    lr_n = csr_lr; scratch_n = csr_scratch;
    mode_n = priv_mode; ha_n = handler_active; halt_n = halt;
    rf_we = 1'b0; rf_wd = '0; dm_we = 1'b0; ill = 1'b0;
    if (halt) begin
      pc_n = pc;
    end else if (!irq_take) begin
      case (op)
        OP_ALUI: begin
          ill = !alu_ok;
          rf_we = alu_ok; rf_wd = alu_res;
        end
        OP_LD: begin rf_we = 1'b1; rf_wd = dmem[daddr]; end
        OP_ST: dm_we = 1'b1;
        OP_CSR: begin
          if (cfunc > 4'd3 || !csr_known) ill = 1'b1;
          else if (priv_mode == 2'd0 && !(cfunc == 4'd0 && caddr == A_CYCLE)) ill = 1'b1;
          else if (cfunc != 4'd0 && caddr == A_CYCLE) ill = 1'b1;
          else if (cfunc != 4'd0 && caddr == A_STATUS &&
                   (csr_wdata[1:0] == 2'd2 || (priv_mode == 2'd1 && csr_wdata[1:0] == 2'd3)))
            ill = 1'b1;
          else begin
            rf_we = instr[37]; rf_wd = csr_old;
            if (cfunc != 4'd0) begin
              case (caddr)
                A_STATUS:  begin status_n = csr_wdata & STATUS_MASK; mode_n = csr_wdata[1:0]; end
                A_CAUSE:   cause_n = csr_wdata;
                A_EPC:     begin epc_n = csr_wdata; lr_n = csr_wdata; end
                A_LR:      lr_n = csr_wdata;
                A_SCRATCH: scratch_n = csr_wdata;
                default: ;
              endcase
            end
          end
        end
        OP_SYS: begin
          case (instr[3:0])
            4'd0: ;
            4'd1: halt_n = 1'b1;
            4'd2: begin
              if (priv_mode != 2'd3) ill = 1'b1;
              else begin
                pc_n = csr_epc; lr_n = csr_epc;
                mode_n = csr_status[3:2];
                status_n[1:0] = csr_status[3:2];
                status_n[3:2] = 2'd0;
                status_n[6] = csr_status[9];
                status_n[7] = 1'b1;
                status_n[9] = 1'b1;
                ha_n = 1'b0;
              end
            end
            default: ill = 1'b1;
          endcase
        end
        default: ill = 1'b1;
      endcase
    end
    // Trap entry discards every side effect computed above for this instruction.
    if (!halt && (irq_take || ill)) begin
      rf_we = 1'b0; dm_we = 1'b0; halt_n = halt;
      cause_n = irq_take ? irq_cause : 48'd2;
      epc_n = pc; lr_n = pc; scratch_n = csr_scratch;
      status_n = csr_status;
      status_n[3:2] = priv_mode;
      status_n[1:0] = 2'd3;
      status_n[9] = csr_status[6];
      status_n[6] = 1'b0;
      mode_n = 2'd3; ha_n = 1'b1;
      pc_n = 48'(TRAP_VECTOR);
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      pc <= '0; csr_status <= 48'h003; csr_cause <= '0; csr_epc <= '0;
      csr_lr <= '0; csr_scratch <= '0; csr_cycle <= '0;
      priv_mode <= 2'd3; handler_active <= 1'b0; halt <= 1'b0;
    end else begin
      pc <= pc_n; csr_status <= status_n; csr_cause <= cause_n; csr_epc <= epc_n;
      csr_lr <= lr_n; csr_scratch <= scratch_n; csr_cycle <= csr_cycle + 48'd1;
      priv_mode <= mode_n; handler_active <= ha_n; halt <= halt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (dm_we && !resetn) dmem[daddr] <= rv1;
  end
endmodule

// File: tb/tb_cpu_ad48_core.sv
// Scoreboard bench for cpu_ad48_core: small programs preloaded into IMEM, expectations queued then popped.

module tb_cpu_ad48_core;
  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic [3:0] irq = '0;
  logic       halt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [47:0] exp_q[$];

  cpu_ad48_core dut (.clk(clk), .resetn(resetn), .irq(irq), .halt(halt));

  always #5 clk = ~clk;

  localparam logic [5:0] ALUI = 6'h01, LD = 6'h02, ST = 6'h03;
  localparam logic [47:0] NOP = {6'h3F, 38'd0, 4'd0};
  localparam logic [47:0] HLT = {6'h3F, 38'd0, 4'd1};
  localparam logic [47:0] IRT = {6'h3F, 38'd0, 4'd2};

  function automatic logic [47:0] e_ri(input logic [5:0] op, input logic [2:0] rd, input logic [2:0] rs,
                                       input logic [7:0] sub, input logic [26:0] imm);
    return {op, 1'b0, rd, rs, sub, imm};
  endfunction

  function automatic logic [47:0] e_csr(input logic [3:0] fn, input logic wr, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [11:0] addr);
    return {6'h20, fn, wr, rd, rs, 19'd0, addr};
  endfunction

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_v(input logic [47:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_chk(input string tag, input logic [47:0] obs);
    logic [47:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    chk(tag, obs, e);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) dut.IMEM.mem[i] = HLT;
  endtask

  // Holds reset over two clocks; the caller loads IMEM first and releases reset.
  task automatic hold_reset();
    @(negedge clk);
    resetn = 1'b1;
    irq = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic release_reset();
    resetn = 1'b0;
  endtask

  task automatic run_to_halt(input string tag);
    for (int i = 0; i < 2000 && !halt; i++) @(negedge clk);
    chk({tag, "_halt"}, 48'(halt), 48'd1);
  endtask

  task automatic wait_pc(input string tag, input logic [47:0] target);
    for (int i = 0; i < 500 && dut.pc != target; i++) @(negedge clk);
    chk({tag, "_pc"}, dut.pc, target);
  endtask

  task automatic sup_case(input string tag, input logic [47:0] bad_instr, input logic [47:0] bad_pc);
    clear_imem();
    dut.IMEM.mem[0] = e_ri(ALUI, 3'd1, 3'd0, 8'd0, 27'h31);
    dut.IMEM.mem[1] = e_csr(4'd1, 1'b0, 3'd0, 3'd1, 12'h000);
    dut.IMEM.mem[2] = e_ri(ALUI, 3'd2, 3'd0, 8'd0, 27'h33);
    dut.IMEM.mem[bad_pc[7:0]] = bad_instr;
    hold_reset();
    release_reset();
    expect_v(48'd2); expect_v(bad_pc); expect_v(48'h037); expect_v(48'd3); expect_v(48'd1);
    run_to_halt(tag);
    pop_chk({tag, "_cause"}, dut.csr_cause);
    pop_chk({tag, "_epc"}, dut.csr_epc);
    pop_chk({tag, "_status"}, dut.csr_status);
    pop_chk({tag, "_priv"}, 48'(dut.priv_mode));
    pop_chk({tag, "_ha"}, 48'(dut.handler_active));
  endtask

  initial begin
    // Reset state
    clear_imem();
    hold_reset();
    expect_v(48'd0); expect_v(48'h003); expect_v(48'd3); expect_v(48'd0); expect_v(48'd0);
    pop_chk("rst_pc", dut.pc);
    pop_chk("rst_status", dut.csr_status);
    pop_chk("rst_priv", 48'(dut.priv_mode));
    pop_chk("rst_halt", 48'(halt));
    pop_chk("rst_cycle", dut.csr_cycle);
    for (int i = 0; i < 8; i++) begin
      expect_v(48'd0);
      pop_chk($sformatf("rst_d%0d", i), dut.RF_D.regs[i]);
    end

    // Privilege fault from user mode, handler, IRET back to user
    clear_imem();
    dut.IMEM.mem[0] = e_ri(ALUI, 3'd1, 3'd0, 8'd0, 27'h73);
    dut.IMEM.mem[1] = e_ri(ALUI, 3'd2, 3'd0, 8'd0, 27'h71);
    dut.IMEM.mem[2] = e_ri(ALUI, 3'd3, 3'd0, 8'd0, 27'h74);
    dut.IMEM.mem[3] = e_csr(4'd1, 1'b0, 3'd0, 3'd1, 12'h000);
    dut.IMEM.mem[4] = e_csr(4'd1, 1'b0, 3'd0, 3'd2, 12'h000);
    dut.IMEM.mem[5] = e_csr(4'd1, 1'b0, 3'd0, 3'd3, 12'h000);
    for (int i = 6; i < 11; i++) dut.IMEM.mem[i] = NOP;
    dut.IMEM.mem[11] = e_csr(4'd1, 1'b0, 3'd0, 3'd1, 12'h004);
    dut.IMEM.mem[12] = e_csr(4'd0, 1'b1, 3'd2, 3'd0, 12'h005);
    dut.IMEM.mem[13] = HLT;
    dut.IMEM.mem[64] = e_csr(4'd0, 1'b1, 3'd4, 3'd0, 12'h000);
    dut.IMEM.mem[65] = e_csr(4'd0, 1'b1, 3'd5, 3'd0, 12'h001);
    dut.IMEM.mem[66] = e_csr(4'd0, 1'b1, 3'd6, 3'd0, 12'h002);
    dut.IMEM.mem[67] = e_csr(4'd0, 1'b1, 3'd7, 3'd0, 12'h004);
    dut.IMEM.mem[68] = e_ri(ALUI, 3'd1, 3'd0, 8'd0, 27'd12);
    dut.IMEM.mem[69] = e_csr(4'd1, 1'b0, 3'd0, 3'd1, 12'h002);
    dut.IMEM.mem[70] = IRT;
    hold_reset();
    release_reset();
    expect_v(48'h233); expect_v(48'd2); expect_v(48'd11); expect_v(48'd0); expect_v(48'd19);
    expect_v(48'd0); expect_v(48'h2F0); expect_v(48'd0); expect_v(48'd12); expect_v(48'd12);
    expect_v(48'd0);
    run_to_halt("priv");
    pop_chk("priv_d4_status", dut.RF_D.regs[4]);
    pop_chk("priv_d5_cause", dut.RF_D.regs[5]);
    pop_chk("priv_d6_epc", dut.RF_D.regs[6]);
    pop_chk("priv_d7_scratch", dut.RF_D.regs[7]);
    pop_chk("priv_d2_cycle", dut.RF_D.regs[2]);
    pop_chk("priv_mode", 48'(dut.priv_mode));
    pop_chk("priv_status", dut.csr_status);
    pop_chk("priv_scratch", dut.csr_scratch);
    pop_chk("priv_lr", dut.csr_lr);
    pop_chk("priv_epc", dut.csr_epc);
    pop_chk("priv_ha", 48'(dut.handler_active));

    // ALU, LD/ST with address wrap, illegal subop trap
    clear_imem();
    dut.IMEM.mem[0]  = e_ri(ALUI, 3'd1, 3'd0, 8'd2, 27'd0);
    dut.IMEM.mem[1]  = e_ri(ALUI, 3'd1, 3'd1, 8'd0, 27'h73);
    dut.IMEM.mem[2]  = e_ri(ALUI, 3'd1, 3'd1, 8'd1, 27'd1);
    dut.IMEM.mem[3]  = e_ri(ALUI, 3'd2, 3'd0, 8'd0, 27'h7FF_FFFF);
    dut.IMEM.mem[4]  = e_ri(ALUI, 3'd3, 3'd0, 8'd0, 27'h1234);
    dut.IMEM.mem[5]  = e_ri(ALUI, 3'd4, 3'd0, 8'd0, 27'd1);
    dut.IMEM.mem[6]  = e_ri(ST,   3'd3, 3'd4, 8'd0, 27'd32);
    dut.IMEM.mem[7]  = e_ri(LD,   3'd5, 3'd0, 8'd0, 27'd1);
    dut.IMEM.mem[8]  = e_ri(ALUI, 3'd6, 3'd2, 8'd4, 27'hFF);
    dut.IMEM.mem[9]  = e_ri(ALUI, 3'd7, 3'd1, 8'd3, 27'h100);
    dut.IMEM.mem[10] = e_ri(ALUI, 3'd1, 3'd1, 8'd7, 27'd5);
    hold_reset();
    release_reset();
    expect_v(48'h72); expect_v(48'hFFFF_FFFF_FFFF); expect_v(48'h1234); expect_v(48'h1234);
    expect_v(48'hFFFF_FFFF_FF00); expect_v(48'h172); expect_v(48'd2); expect_v(48'd10);
    expect_v(48'h00F); expect_v(48'd1);
    run_to_halt("alu");
    pop_chk("alu_d1_sub", dut.RF_D.regs[1]);
    pop_chk("alu_d2_neg", dut.RF_D.regs[2]);
    pop_chk("ldst_d5", dut.RF_D.regs[5]);
    pop_chk("ldst_dm1", dut.dmem[1]);
    pop_chk("alu_d6_xor", dut.RF_D.regs[6]);
    pop_chk("alu_d7_or", dut.RF_D.regs[7]);
    pop_chk("alu_ill_cause", dut.csr_cause);
    pop_chk("alu_ill_epc", dut.csr_epc);
    pop_chk("alu_ill_status", dut.csr_status);
    pop_chk("alu_ill_ha", 48'(dut.handler_active));

    // Interrupt in machine mode; no re-entry until IRET
    clear_imem();
    dut.IMEM.mem[0] = e_ri(ALUI, 3'd1, 3'd0, 8'd0, 27'h43);
    dut.IMEM.mem[1] = e_csr(4'd1, 1'b0, 3'd0, 3'd1, 12'h000);
    for (int i = 2; i < 20; i++) dut.IMEM.mem[i] = NOP;
    for (int i = 64; i < 67; i++) dut.IMEM.mem[i] = NOP;
    dut.IMEM.mem[67] = e_csr(4'd0, 1'b1, 3'd2, 3'd0, 12'h001);
    dut.IMEM.mem[68] = e_csr(4'd0, 1'b1, 3'd3, 3'd0, 12'h002);
    dut.IMEM.mem[69] = IRT;
    hold_reset();
    release_reset();
    wait_pc("irq_pre", 48'd5);
    irq = 4'b1100;
    expect_v(48'd64); expect_v(48'd10); expect_v(48'd5); expect_v(48'd0); expect_v(48'd1);
    @(negedge clk);
    pop_chk("irq_pc", dut.pc);
    pop_chk("irq_cause", dut.csr_cause);
    pop_chk("irq_epc", dut.csr_epc);
    pop_chk("irq_mie", 48'(dut.csr_status[6]));
    pop_chk("irq_ha", 48'(dut.handler_active));
    wait_pc("irq_hnd", 48'd69);
    expect_v(48'd10); expect_v(48'd5);
    pop_chk("irq_noreentry_cause", dut.csr_cause);
    pop_chk("irq_noreentry_epc", dut.csr_epc);
    irq = '0;
    expect_v(48'd10); expect_v(48'd5); expect_v(48'h2C3); expect_v(48'd0); expect_v(48'd5);
    run_to_halt("irq");
    pop_chk("irq_d2", dut.RF_D.regs[2]);
    pop_chk("irq_d3", dut.RF_D.regs[3]);
    pop_chk("irq_status_after", dut.csr_status);
    pop_chk("irq_ha_after", 48'(dut.handler_active));
    pop_chk("irq_lr", dut.csr_lr);

    // Supervisor: STATUS write with mode 3, and IRET, both trap
    sup_case("sup_wr3", e_csr(4'd1, 1'b0, 3'd0, 3'd2, 12'h000), 48'd3);
    sup_case("sup_iret", IRT, 48'd2);

    // Reset mid-program
    clear_imem();
    dut.IMEM.mem[0] = e_ri(ALUI, 3'd1, 3'd0, 8'd0, 27'd5);
    dut.IMEM.mem[1] = e_csr(4'd1, 1'b0, 3'd0, 3'd1, 12'h004);
    for (int i = 2; i < 200; i++) dut.IMEM.mem[i] = NOP;
    hold_reset();
    release_reset();
    for (int i = 0; i < 20; i++) @(negedge clk);
    resetn = 1'b1;
    #1;
    expect_v(48'd0); expect_v(48'h003); expect_v(48'd0); expect_v(48'd0);
    expect_v(48'd0); expect_v(48'd0); expect_v(48'd3);
    pop_chk("mrst_pc", dut.pc);
    pop_chk("mrst_status", dut.csr_status);
    pop_chk("mrst_halt", 48'(halt));
    pop_chk("mrst_cycle", dut.csr_cycle);
    pop_chk("mrst_scratch", dut.csr_scratch);
    pop_chk("mrst_d1", dut.RF_D.regs[1]);
    pop_chk("mrst_priv", 48'(dut.priv_mode));
    @(negedge clk);
    release_reset();
    for (int i = 0; i < 3; i++) @(negedge clk);
    expect_v(48'd3);
    pop_chk("mrst_cycle_restart", dut.csr_cycle);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cpu_ad48_core.md
Name: cpu_ad48_core

Overview:
- Single-issue 48-bit processor core with internal instruction memory, data memory, an 8-entry data register file and a small CSR file.
- Implements user (0), supervisor (1) and machine (3) privilege modes, illegal-instruction traps, level interrupts, and IRET.
- Top-level compute block. Programs are preloaded into instruction memory by the bench.

Parameters:
- IM_WORDS, 256, instruction memory depth in 48-bit words.
- DM_WORDS, 32, data memory depth in 48-bit words.
- IRQ_LINES, 4, number of interrupt request inputs.
- TRAP_VECTOR, 64, PC loaded on trap or interrupt entry.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-high reset. The core is held in reset while resetn=1.
- irq  in  IRQ_LINES  level-sensitive interrupt requests.
- halt  out  1  high once HALT has executed; sticky until reset.

Behaviour:
- Required hierarchy (benches access these names directly):
  - IMEM.mem[IM_WORDS] 48b, combinational read.
  - RF_D.regs[0:7] 48b.
  - Registers csr_status, csr_cause, csr_epc, csr_lr, csr_scratch, csr_cycle (all 48b), priv_mode[1:0], handler_active, halt.
- Reset values:
  - pc=0, all regs 0, csr_status=0x003, priv_mode=3.
  - Remaining CSRs 0, halt=0, handler_active=0.
- Execution model:
  - One instruction per clock: fetch IMEM.mem[pc mod IM_WORDS], execute, then pc+1.
  - While halt=1 there is no fetch and no state change, except that csr_cycle keeps counting.
  - csr_cycle increments every clock out of reset.
- Encoding: op=[47:42].
  - ALUI op=0x01.
    - Fields: [40:38] rd, [37:35] rs, [34:27] subop, [26:0] imm27 (sign-extended to 48b).
    - rd <= rs OP imm, with ADD=0, SUB=1, AND=2, OR=3, XOR=4. Other subops are illegal.
    - Arithmetic is modulo 2^48.
  - LD op=0x02: rd <= DM[(rs+imm) mod DM_WORDS]. Same field layout as ALUI.
  - ST op=0x03: DM[(rs+imm) mod DM_WORDS] <= reg[rd]. Same field layout as ALUI.
  - CSR op=0x20.
    - Fields: [41:38] func (R=0, RW=1, RS=2, RC=3), [37] wr_rd, [36:34] rd, [33:31] rs, [11:0] addr.
    - If wr_rd=1: rd <= old CSR value.
    - Write data: RW writes rs; RS writes old|rs; RC writes old&~rs.
  - SYS op=0x3F, func=[3:0]: NOP=0, HALT=1, IRET=2.
  - Any other opcode or func is illegal.
- CSR addresses: STATUS=0x000, CAUSE=0x001, EPC=0x002, LR=0x003, SCRATCH=0x004, CYCLE=0x005 (read-only). Unknown addresses are illegal.
- STATUS bit layout:
  - [1:0] current mode, [3:2] prev mode.
  - UIE=4, KIE=5, MIE=6, UPIE=7, KPIE=8, MPIE=9.
  - Other bits read 0.
  - Writing STATUS also sets priv_mode to the written [1:0]. Mode value 2 is illegal.
- Writing EPC also copies the written value into LR.
- Privilege checks:
  - User mode: only CSR R of CYCLE is allowed. Any other CSR access, and IRET, is illegal.
  - Supervisor mode: all CSR accesses allowed, except a STATUS write with mode=3, which is illegal. IRET is illegal.
  - Machine mode: everything allowed.
  - An illegal instruction has no architectural side effect.
- Trap entry (illegal instruction at P), all in the same edge:
  - EPC=LR=P, CAUSE=2.
  - prev mode <= current mode, mode <= 3, priv_mode <= 3.
  - MPIE <= MIE, MIE <= 0. UIE and KIE are unchanged.
  - handler_active=1, pc=TRAP_VECTOR.
- Interrupts:
  - Checked before executing the instruction at pc.
  - Taken if some irq[i]=1, the IE bit of the current mode is set, handler_active=0 and halt=0.
  - Lowest index i wins. CAUSE=8+i, EPC=LR=pc (that instruction is not executed). Rest is the same as trap entry.
  - An illegal instruction never coexists with an interrupt, because the interrupt is taken first.
- IRET (machine mode only):
  - pc <= EPC, LR <= EPC.
  - mode and priv_mode <= prev mode, prev <= 0.
  - MIE <= MPIE, MPIE <= 1, UPIE <= 1. KPIE, UIE and KIE are unchanged.
  - handler_active <= 0.
- Reset asserted mid-operation immediately restores all reset values.

Test Plan:
- Privilege fault:
  - Stimulus: from machine mode write STATUS=0x73, then 0x71, then 0x74 (user, prev=1). In user mode CSR RW SCRATCH with rs=1 at PC 11.
  - Handler at 64 reads STATUS, CAUSE, EPC, SCRATCH into D4..D7, sets EPC=12, then IRET. PC 12 is CSR R CYCLE; PC 13 is HALT.
  - Required: D4[1:0]=3, D4[3:2]=0, MIE=0, MPIE=1, UIE=KIE=1; D5=2; D6=11; D7=0.
  - After HALT: priv_mode=0, STATUS mode=0, prev=0, MIE=UIE=KIE=UPIE=MPIE=1, SCRATCH=0, LR=EPC=12, handler_active=0.
- ALU: ANDI 0 then ADDI 0x073, then SUBI 1 on D1 -> D1=0x72. ADD of imm27=-1 to 0 -> 0xFFFFFFFFFFFF.
- LD/ST: store 0x1234 at address 33 (wraps to 1), then load -> value read back; DM[1]=0x1234.
- Interrupt: in machine mode with MIE=1, raise irq[2] -> CAUSE=10, pc=64, EPC=interrupted pc, MIE=0. A second irq is not taken until IRET.
- Supervisor IRET or STATUS write with mode=3 -> CAUSE=2 trap, STATUS unchanged apart from the trap-entry fields.
- Reset: assert resetn mid-program -> pc=0, STATUS=0x003, halt=0; CYCLE restarts from 0.
